spi_peripheral: RTL and testbench
=================================

# spi_peripheral

SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) for the system clock domain, the counterpart to our SPI initiator logic. It oversamples the external SCLK, CS_n and MOSI pins with the system clock and deserialises WIDTH-bit words onto a strobed parallel output. At the same time it serialises words supplied over a valid/ready handshake onto MISO. It sits between the pad ring and the register/command logic that services an external host.

## Interface
- WIDTH, 8: bits per SPI word (≥2).
- SYNC_STAGES, 2: synchroniser flops per pin input (≥2).

- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock pin, asynchronous to clock.
- cs_n  in  1  SPI chip select pin, active low, asynchronous.
- mosi  in  1  SPI data in, asynchronous.
- miso  out  1  SPI data out, registered.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmit holding buffer is empty.
- rx_data  out  WIDTH  last complete received word, held.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- busy  out  1  synchronised cs_n is asserted.

## Operation
- Synchronisation:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Synchroniser reset values: sclk 0, cs_n 1, mosi 0.
  - A last-value register on synced sclk and cs_n gives sclk_rise, sclk_fall, cs_fall and cs_rise strobes.
- States:
  - IDLE: synced cs_n high. miso = 0, bit_cnt = 0.
  - ACTIVE: synced cs_n low.
  - IDLE→ACTIVE on cs_fall. ACTIVE→IDLE on cs_rise.
- Transmit holding buffer (one entry):
  - tx_ready = buffer empty.
  - tx_valid && tx_ready captures tx_data; the buffer is then full.
  - The buffer empties when its word is loaded into the TX shifter.
- Shifter load:
  - Occurs on cs_fall, and on the sclk_fall that follows word completion.
  - Loads the buffer word if the buffer is full; otherwise loads the fill word (0 by default).
  - After the load, miso = shifter MSB.
  - If a load and a tx capture fall on the same cycle, the load takes the old buffer state, and the new word is captured in that same cycle only if tx_ready was 1.
- sclk_rise in ACTIVE:
  - rx_shift ← {rx_shift[WIDTH-2:0], mosi_sync}.
  - bit_cnt increments.
  - When bit_cnt == WIDTH-1: rx_data ← completed word, rx_valid = 1 the next cycle, bit_cnt wraps to 0.
- sclk_fall in ACTIVE:
  - If bit_cnt == 0 (word just completed): shifter load.
  - Otherwise: TX shifter shifts left and miso = new MSB.
- Streaming: consecutive words under one cs_n assertion are supported without gaps.
- cs_rise mid-word:
  - Partial RX word is discarded; no rx_valid.
  - bit_cnt → 0.
  - Any unsent shifter contents are dropped; the holding buffer is untouched.
- rx_valid has no backpressure. The consumer must take rx_data before the next completed word; rx_data is overwritten silently.
- sclk edges while in IDLE are ignored.
- Reset values: miso 0, rx_data 0, rx_valid 0, tx_ready 1, busy 0, bit_cnt 0, holding buffer empty.

## Timing
- Pin edge to internal strobe: SYNC_STAGES+1 clock cycles.
- MOSI is sampled from the synchronised copy on the strobe cycle; mosi must be stable SYNC_STAGES+1 cycles around the sclk rising edge.
- MISO changes SYNC_STAGES+2 cycles after the sclk falling pin edge, and SYNC_STAGES+2 cycles after the cs_n falling pin edge.
- Host constraints:
  - sclk high and low phases each ≥ SYNC_STAGES+3 clock periods.
  - cs_n fall to first sclk rise ≥ SYNC_STAGES+3 clock periods.
  - Last sclk fall to cs_n rise ≥ 2 clock periods.
- rx_valid asserts 1 cycle after the strobe of the WIDTH-th sclk_rise, and lasts exactly 1 cycle.
- tx_ready rises the cycle after the load that empties the buffer.

## Configuration
- SPI_PERIPH_ECHO_EN:
  - Defined: the fill word is the most recent completed rx_data, i.e. an empty buffer echoes the last received word. After reset this is 0.
  - Undefined: the fill word is all zeros.
- The macro does not change ports or timing.

## Test plan
- Reset mid-transfer: assert reset_n low during bit 3 → all outputs reach reset values immediately; the next full transfer behaves as from power-up.
- Single word, WIDTH=8: preload tx_data=0xA5; host sends 0x3C under one cs_n → miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C with one rx_valid pulse; tx_ready returns to 1.
- Streaming: host clocks 3 words 0x01, 0x02, 0x03 while tx_data 0x11, 0x22, 0x33 is supplied on each tx_ready → three rx_valid pulses with matching rx_data; miso carries 0x11, 0x22, 0x33.
- Underrun: buffer empty at cs_fall, host sends 0x5A → miso all 0 with the macro undefined. With SPI_PERIPH_ECHO_EN and a previous rx of 0x3C, miso = 0x3C.
- Abort: cs_n rises after 5 bits → no rx_valid, rx_data unchanged; a buffered tx word (loaded after the abort) is sent intact in the next transfer.
- IDLE noise: toggle sclk 16 times with cs_n high → no rx_valid, miso stays 0, tx_ready unchanged.

Source files
------------

// File: rtl/spi_peripheral_if.sv
// rtl/spi_peripheral_if.sv - pin and parallel-side signal bundle for spi_peripheral
interface spi_peripheral_if #(
    parameter int WIDTH = 8
);
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - oversampled SPI mode-0 responder; SPI_PERIPH_ECHO_EN makes underruns echo the last rx word
module spi_peripheral #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    spi_peripheral_if.slave   bus
);
    localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_last;
    logic                   r_cs_last;

    logic [WIDTH-1:0] r_buf;
    logic             r_buf_full;
    logic [WIDTH-1:0] r_tx_shift;
    logic [WIDTH-2:0] r_rx_shift;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_miso;
    logic [CW-1:0]    r_bit_cnt;

    logic             w_sclk;
    logic             w_cs_n;
    logic             w_mosi;
    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_cs_fall;
    logic             w_cs_rise;
    logic             w_active;
    logic             w_rise;
    logic             w_fall;
    logic             w_load;
    logic             w_shift;
    logic             w_capture;
    logic             w_abort;
    logic [WIDTH-1:0] w_fill;
    logic [WIDTH-1:0] w_load_word;
    logic [WIDTH-1:0] w_rx_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_last <= 1'b0;
            r_cs_last   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_sclk_last <= w_sclk;
            r_cs_last   <= w_cs_n;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_last;
    assign w_sclk_fall = ~w_sclk & r_sclk_last;
    assign w_cs_fall   = ~w_cs_n & r_cs_last;
    assign w_cs_rise   = w_cs_n & ~r_cs_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cs_fall) w_state_next = S_ACTIVE;
            S_ACTIVE: if (w_cs_rise) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

`ifdef SPI_PERIPH_ECHO_EN
    assign w_fill = r_rx_data;
`else
    assign w_fill = '0;
`endif

    // A deselect wins over any sclk edge seen in the same cycle.
    assign w_active    = (r_state == S_ACTIVE);
    assign w_abort     = w_active && w_cs_rise;
    assign w_rise      = w_active && w_sclk_rise && !w_cs_rise;
    assign w_fall      = w_active && w_sclk_fall && !w_cs_rise;
    assign w_load      = ((r_state == S_IDLE) && w_cs_fall) || (w_fall && (r_bit_cnt == '0));
    assign w_shift     = w_fall && (r_bit_cnt != '0);
    assign w_capture   = bus.tx_valid && !r_buf_full;
    assign w_load_word = r_buf_full ? r_buf : w_fill;
    assign w_rx_next   = {r_rx_shift, w_mosi};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b0;
            r_bit_cnt  <= '0;
        end else begin
            r_rx_valid <= 1'b0;

            // Load sees the old buffer; capture is only possible while it was empty.
            if (w_capture) begin
                r_buf      <= bus.tx_data;
                r_buf_full <= 1'b1;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end

            if (w_abort) begin
                r_tx_shift <= '0;
                r_miso     <= 1'b0;
            end else if (w_load) begin
                r_tx_shift <= w_load_word;
                r_miso     <= w_load_word[WIDTH-1];
            end else if (w_shift) begin
                r_tx_shift <= r_tx_shift << 1;
                r_miso     <= r_tx_shift[WIDTH-2];
            end

            if (w_abort) begin
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
            end else if (w_rise) begin
                r_rx_shift <= w_rx_next[WIDTH-2:0];
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.miso     = r_miso;
    assign bus.tx_ready = ~r_buf_full;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.busy     = ~w_cs_n;
endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - directed self-checking bench for spi_peripheral
module tb_spi_peripheral;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   rx_cnt  = 0;
    logic [7:0] rx_log [0:15];

    spi_peripheral_if #(.WIDTH(8)) bus ();

    spi_peripheral #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.rx_valid === 1'b1) begin
            rx_log[rx_cnt & 15] = bus.rx_data;
            rx_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [7:0] w);
        @(negedge clock);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        @(negedge clock);
        bus.tx_valid = 1'b0;
    endtask

    task automatic cs_begin();
        @(negedge clock);
        bus.cs_n = 1'b0;
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clock);
        bus.cs_n = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic spi_bits(input logic [7:0] w, input int n, output logic [7:0] m);
        m = 8'h00;
        for (int b = 0; b < n; b++) begin
            bus.mosi = w[7-b];
            repeat (8) @(negedge clock);
            m[7-b] = bus.miso;
            bus.sclk = 1'b1;
            repeat (8) @(negedge clock);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        n_cmp++; if (bus.miso !== 1'b0) begin $display("FAIL reset_miso: got %b expected 0", bus.miso); n_err++; end
        n_cmp++; if (bus.rx_data !== 8'h00) begin $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); n_err++; end
        n_cmp++; if (bus.rx_valid !== 1'b0) begin $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); n_err++; end
        n_cmp++; if (bus.tx_ready !== 1'b1) begin $display("FAIL reset_tx_ready: got %b expected 1", bus.tx_ready); n_err++; end
        n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", bus.busy); n_err++; end
    endtask

    task automatic test_single();
        logic [7:0] m;
        int base;
        base = rx_cnt;
        preload(8'hA5);
        n_cmp++; if (bus.tx_ready !== 1'b0) begin $display("FAIL single_tx_full: got %b expected 0", bus.tx_ready); n_err++; end
        cs_begin();
        spi_bits(8'h3C, 8, m);
        n_cmp++; if (bus.busy !== 1'b1) begin $display("FAIL single_busy: got %b expected 1", bus.busy); n_err++; end
        cs_end();
        n_cmp++; if (m !== 8'hA5) begin $display("FAIL single_miso: got %h expected a5", m); n_err++; end
        n_cmp++; if (rx_cnt - base !== 1) begin $display("FAIL single_rx_pulses: got %0d expected 1", rx_cnt - base); n_err++; end
        n_cmp++; if (rx_log[base & 15] !== 8'h3C) begin $display("FAIL single_rx_word: got %h expected 3c", rx_log[base & 15]); n_err++; end
        n_cmp++; if (bus.rx_data !== 8'h3C) begin $display("FAIL single_rx_data: got %h expected 3c", bus.rx_data); n_err++; end
        n_cmp++; if (bus.tx_ready !== 1'b1) begin $display("FAIL single_tx_ready: got %b expected 1", bus.tx_ready); n_err++; end
        n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL single_busy_end: got %b expected 0", bus.busy); n_err++; end
    endtask

    task automatic test_underrun();
        logic [7:0] m;
        logic [7:0] exp_m;
`ifdef SPI_PERIPH_ECHO_EN
        exp_m = 8'h3C;
`else
        exp_m = 8'h00;
`endif
        cs_begin();
        spi_bits(8'h5A, 8, m);
        cs_end();
        n_cmp++; if (m !== exp_m) begin $display("FAIL underrun_miso: got %h expected %h", m, exp_m); n_err++; end
        n_cmp++; if (bus.rx_data !== 8'h5A) begin $display("FAIL underrun_rx_data: got %h expected 5a", bus.rx_data); n_err++; end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m0, m1, m2;
        logic [7:0] txw [0:2];
        int base;
        txw[0] = 8'h11; txw[1] = 8'h22; txw[2] = 8'h33;
        base = rx_cnt;
        preload(txw[0]);
        fork
            begin
                for (int k = 1; k < 3; k++) begin
                    int n;
                    n = 0;
                    while (bus.tx_ready !== 1'b1 && n < 1000) begin
                        @(negedge clock);
                        n++;
                    end
                    n_cmp++;
                    if (n >= 1000) begin $display("FAIL stream_tx_ready_wait: got timeout expected tx_ready for word %0d", k); n_err++; end
                    bus.tx_data  = txw[k];
                    bus.tx_valid = 1'b1;
                    @(negedge clock);
                    bus.tx_valid = 1'b0;
                end
            end
            begin
                cs_begin();
                spi_bits(8'h01, 8, m0);
                spi_bits(8'h02, 8, m1);
                spi_bits(8'h03, 8, m2);
                cs_end();
            end
        join
        n_cmp++; if (m0 !== 8'h11) begin $display("FAIL stream_miso0: got %h expected 11", m0); n_err++; end
        n_cmp++; if (m1 !== 8'h22) begin $display("FAIL stream_miso1: got %h expected 22", m1); n_err++; end
        n_cmp++; if (m2 !== 8'h33) begin $display("FAIL stream_miso2: got %h expected 33", m2); n_err++; end
        n_cmp++; if (rx_cnt - base !== 3) begin $display("FAIL stream_rx_pulses: got %0d expected 3", rx_cnt - base); n_err++; end
        n_cmp++; if (rx_log[base & 15] !== 8'h01) begin $display("FAIL stream_rx0: got %h expected 01", rx_log[base & 15]); n_err++; end
        n_cmp++; if (rx_log[(base + 1) & 15] !== 8'h02) begin $display("FAIL stream_rx1: got %h expected 02", rx_log[(base + 1) & 15]); n_err++; end
        n_cmp++; if (rx_log[(base + 2) & 15] !== 8'h03) begin $display("FAIL stream_rx2: got %h expected 03", rx_log[(base + 2) & 15]); n_err++; end
    endtask

    task automatic test_abort();
        logic [7:0] m;
        int base;
        base = rx_cnt;
        cs_begin();
        spi_bits(8'hF0, 5, m);
        cs_end();
        n_cmp++; if (rx_cnt - base !== 0) begin $display("FAIL abort_rx_pulses: got %0d expected 0", rx_cnt - base); n_err++; end
        n_cmp++; if (bus.rx_data !== 8'h03) begin $display("FAIL abort_rx_data: got %h expected 03", bus.rx_data); n_err++; end
        n_cmp++; if (bus.miso !== 1'b0) begin $display("FAIL abort_miso_idle: got %b expected 0", bus.miso); n_err++; end
        preload(8'hC3);
        cs_begin();
        spi_bits(8'h96, 8, m);
        cs_end();
        n_cmp++; if (m !== 8'hC3) begin $display("FAIL abort_next_miso: got %h expected c3", m); n_err++; end
        n_cmp++; if (bus.rx_data !== 8'h96) begin $display("FAIL abort_next_rx: got %h expected 96", bus.rx_data); n_err++; end
    endtask

    task automatic test_idle_noise();
        logic [7:0] m;
        logic       miso_seen;
        int base;
        base = rx_cnt;
        miso_seen = 1'b0;
        preload(8'h77);
        for (int t = 0; t < 16; t++) begin
            bus.sclk = 1'b1;
            repeat (6) begin @(negedge clock); miso_seen = miso_seen | bus.miso; end
            bus.sclk = 1'b0;
            repeat (6) begin @(negedge clock); miso_seen = miso_seen | bus.miso; end
        end
        n_cmp++; if (rx_cnt - base !== 0) begin $display("FAIL noise_rx_pulses: got %0d expected 0", rx_cnt - base); n_err++; end
        n_cmp++; if (miso_seen !== 1'b0) begin $display("FAIL noise_miso: got %b expected 0", miso_seen); n_err++; end
        n_cmp++; if (bus.tx_ready !== 1'b0) begin $display("FAIL noise_tx_ready: got %b expected 0", bus.tx_ready); n_err++; end
        cs_begin();
        spi_bits(8'h00, 8, m);
        cs_end();
        n_cmp++; if (m !== 8'h77) begin $display("FAIL noise_next_miso: got %h expected 77", m); n_err++; end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        int base;
        base = rx_cnt;
        preload(8'hE7);
        cs_begin();
        spi_bits(8'hFF, 3, m);
        bus.sclk = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.miso !== 1'b0) begin $display("FAIL midrst_miso: got %b expected 0", bus.miso); n_err++; end
        n_cmp++; if (bus.rx_data !== 8'h00) begin $display("FAIL midrst_rx_data: got %h expected 00", bus.rx_data); n_err++; end
        n_cmp++; if (bus.tx_ready !== 1'b1) begin $display("FAIL midrst_tx_ready: got %b expected 1", bus.tx_ready); n_err++; end
        n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL midrst_busy: got %b expected 0", bus.busy); n_err++; end
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        n_cmp++; if (rx_cnt - base !== 0) begin $display("FAIL midrst_rx_pulses: got %0d expected 0", rx_cnt - base); n_err++; end
        base = rx_cnt;
        preload(8'hA5);
        cs_begin();
        spi_bits(8'h3C, 8, m);
        cs_end();
        n_cmp++; if (m !== 8'hA5) begin $display("FAIL midrst_next_miso: got %h expected a5", m); n_err++; end
        n_cmp++; if (rx_cnt - base !== 1) begin $display("FAIL midrst_next_pulses: got %0d expected 1", rx_cnt - base); n_err++; end
        n_cmp++; if (bus.rx_data !== 8'h3C) begin $display("FAIL midrst_next_rx: got %h expected 3c", bus.rx_data); n_err++; end
    endtask

    initial begin
        test_reset();
        test_single();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_idle_noise();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
